// File: rtl/ntt_bank_sched.sv
// Bank/row address scheduler and crossbar-select generator for the 8-bank NTT coefficient memory.
// Define NTT_BANK_CONFLICT_CHK_EN to build the sticky bank-conflict checker (conflict_err).
module ntt_bank_lane #(
  parameter int ADDR_W = 7,
  parameter int LANE   = 0
) (
  input  logic [4:0]        v0,
  input  logic [1:0]        v1,
  input  logic [1:0]        v2,
  input  logic [ADDR_W-1:0] cnt,
  output logic [2:0]        bank,
  output logic [ADDR_W-1:0] row
);
  localparam int LOG_N = ADDR_W + 3;
  localparam int NCH   = (LOG_N + 2) / 3;
  localparam logic [2:0] K = 3'(LANE);

  logic [3*NCH-1:0] idx;
  logic [ADDR_W-1:0] rem;

  // lane bits land on v0/v1/v2; counter bits fill the other positions LSB first
  always_comb begin
    idx  = '0;
    rem  = cnt;
    bank = '0;
    for (int b = 0; b < LOG_N; b++) begin
      if (v0 == 5'(b))                 idx[b] = K[0];
      else if (b < 3 && v1 == 2'(b))   idx[b] = K[1];
      else if (b < 3 && v2 == 2'(b))   idx[b] = K[2];
      else begin
        idx[b] = rem[0];
        rem    = rem >> 1;
      end
    end
    for (int q = 0; q < NCH; q++) bank = bank ^ idx[3*q +: 3];
  end

  assign row = idx[LOG_N-1:3];
endmodule

module ntt_bank_sched #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              issue_ready,
  output logic              issue_valid,
  output logic [4:0]        stage,
  output logic [ADDR_W-1:0] lane_addr_0, lane_addr_1, lane_addr_2, lane_addr_3,
  output logic [ADDR_W-1:0] lane_addr_4, lane_addr_5, lane_addr_6, lane_addr_7,
  output logic [2:0]        sel_0, sel_1, sel_2, sel_3, sel_4, sel_5, sel_6, sel_7,
  output logic              busy,
  output logic              done,
  output logic              conflict_err
);
  localparam int NUM_LANES = 8;
  localparam int LOG_N     = ADDR_W + 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_n;

  logic [4:0]        s, s_n;
  logic [ADDR_W-1:0] c, c_n;
  logic [1:0]        v1, v2;
  logic [4:0]        s_mod3;

  logic [NUM_LANES-1:0][2:0]        bank_n;
  logic [NUM_LANES-1:0][ADDR_W-1:0] row_n, row_q;
  logic [NUM_LANES-1:0][2:0]        sel_n, sel_q;
  logic                             dup_n;

  always_comb begin
    state_n = state;
    s_n     = s;
    c_n     = c;
    case (state)
      IDLE: if (start) begin
        state_n = ISSUE;
        s_n     = '0;
        c_n     = '0;
      end
      ISSUE: if (issue_ready) begin
        if (c == {ADDR_W{1'b1}}) begin
          c_n = '0;
          if (s == 5'(LOG_N-1)) begin
            state_n = DONE;
            s_n     = '0;
          end else s_n = s + 5'd1;
        end else c_n = c + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // the two low varied bits are the {0,1,2} positions whose residue mod 3 differs from s
  assign s_mod3 = s_n % 5'd3;
  always_comb begin
    v1 = 2'd1;
    v2 = 2'd2;
    case (s_mod3)
      5'd1:    begin v1 = 2'd0; v2 = 2'd2; end
      5'd2:    begin v1 = 2'd0; v2 = 2'd1; end
      default: begin v1 = 2'd1; v2 = 2'd2; end
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    ntt_bank_lane #(.ADDR_W(ADDR_W), .LANE(k)) u_lane (
      .v0(s_n), .v1(v1), .v2(v2), .cnt(c_n), .bank(bank_n[k]), .row(row_n[k])
    );
  end

  always_comb begin
    sel_n = '0;
    dup_n = 1'b0;
`ifdef NTT_BANK_CONFLICT_CHK_EN
    begin
      logic [NUM_LANES-1:0] claimed;
      claimed = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (claimed[bank_n[k]]) dup_n = 1'b1;
        claimed[bank_n[k]] = 1'b1;
        sel_n[bank_n[k]]   = 3'(k);
      end
    end
`else
    for (int k = 0; k < NUM_LANES; k++) sel_n[bank_n[k]] = 3'(k);
`endif
  end

  // outputs register the group about to be current, so they line up with (s,c)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      s           <= '0;
      c           <= '0;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stage       <= '0;
      row_q       <= '0;
      sel_q       <= '0;
    end else begin
      state       <= state_n;
      s           <= s_n;
      c           <= c_n;
      issue_valid <= (state_n == ISSUE);
      busy        <= (state_n == ISSUE);
      done        <= (state_n == DONE);
      stage       <= (state_n == ISSUE) ? s_n : 5'd0;
      row_q       <= (state_n == ISSUE) ? row_n : '0;
      sel_q       <= (state_n == ISSUE) ? sel_n : '0;
    end
  end

`ifdef NTT_BANK_CONFLICT_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                 conflict_err <= 1'b0;
    else if (state == IDLE && start)            conflict_err <= dup_n;
    else if (state_n == ISSUE && dup_n)         conflict_err <= 1'b1;
  end
`else
  logic unused_dup;
  assign unused_dup   = dup_n;
  assign conflict_err = 1'b0;
`endif

  assign {lane_addr_7, lane_addr_6, lane_addr_5, lane_addr_4,
          lane_addr_3, lane_addr_2, lane_addr_1, lane_addr_0} = row_q;
  assign {sel_7, sel_6, sel_5, sel_4, sel_3, sel_2, sel_1, sel_0} = sel_q;
endmodule
